oam_dma_arbiter: RTL and testbench



---
 rtl/oam_dma_arbiter_if.sv | 26 ++
 rtl/oam_dma_arbiter.sv | 129 ++++++++++++
 tb/tb_oam_dma_arbiter.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/oam_dma_arbiter_if.sv
// rtl/oam_dma_arbiter_if.sv - CPU and memory-fabric signal bundle for the OAM DMA arbiter
// slave is the arbiter's view; master is the CPU/fabric side driving it.
interface oam_dma_arbiter_if;
  logic [15:0] cpu_addr;
  logic        cpu_we;
  logic        cpu_re;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic        mem_re;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        dma_active;
  logic [7:0]  dma_src;

  modport slave (
    input  cpu_addr, cpu_we, cpu_re, cpu_wdata, mem_rdata,
    output cpu_rdata, mem_addr, mem_we, mem_re, mem_wdata, dma_active, dma_src
  );

  modport master (
    output cpu_addr, cpu_we, cpu_re, cpu_wdata, mem_rdata,
    input  cpu_rdata, mem_addr, mem_we, mem_re, mem_wdata, dma_active, dma_src
  );
endinterface

// File: rtl/oam_dma_arbiter.sv
// rtl/oam_dma_arbiter.sv - shared memory bus arbiter with FF46-triggered OAM DMA copy
// CPU passes straight through while idle; during a transfer the DMA owns mem_* exclusively.
module oam_dma_arbiter #(
  parameter int unsigned DMA_LEN      = 160,
  parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
  parameter logic [15:0] DEST_BASE    = 16'hFE00,
  parameter int unsigned START_DELAY  = 1
) (
  input logic               clock,
  input logic               reset_n,
  oam_dma_arbiter_if.slave  bus
);

  localparam int unsigned DW = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
  localparam logic [7:0]    LAST_IDX = 8'(DMA_LEN - 1);
  localparam logic [DW-1:0] DLY_LAST = DW'((START_DELAY > 0) ? START_DELAY - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    START,
    RD,
    WR
  } state_t;

  localparam state_t RESTART = (START_DELAY == 0) ? RD : START;

  state_t        state_q, state_d;
  logic [7:0]    index_q, index_d;
  logic [7:0]    dma_src_q, dma_src_d;
  logic [DW-1:0] dly_q, dly_d;

  logic          reg_hit;
  logic          reg_wr;
  logic [7:0]    src_eff;

  assign reg_hit = (bus.cpu_addr == DMA_REG_ADDR);
  assign reg_wr  = bus.cpu_we && reg_hit;

  // Echo RAM (E000-FFFF) aliases work RAM at C000-DFFF.
  assign src_eff = (dma_src_q >= 8'hE0) ? (dma_src_q - 8'h20) : dma_src_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      index_q   <= 8'h00;
      dma_src_q <= 8'h00;
      dly_q     <= '0;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      dma_src_q <= dma_src_d;
      dly_q     <= dly_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    dma_src_d = dma_src_q;
    dly_d     = dly_q;
    case (state_q)
      START: begin
        if (dly_q == DLY_LAST) begin
          dly_d   = '0;
          state_d = RD;
        end else begin
          dly_d = dly_q + 1'b1;
        end
      end
      RD: state_d = WR;
      WR: begin
        if (index_q == LAST_IDX) begin
          state_d = IDLE;
        end else begin
          index_d = index_q + 8'h01;
          state_d = RD;
        end
      end
      default: state_d = state_q;
    endcase
    // A register write from any state (re)starts the transfer from byte 0.
    if (reg_wr) begin
      dma_src_d = bus.cpu_wdata;
      index_d   = 8'h00;
      dly_d     = '0;
      state_d   = RESTART;
    end
  end

  always_comb begin
    bus.mem_addr  = 16'h0000;
    bus.mem_we    = 1'b0;
    bus.mem_re    = 1'b0;
    bus.mem_wdata = 8'h00;
    if (reset_n) begin
      case (state_q)
        IDLE: begin
          bus.mem_addr  = bus.cpu_addr;
          bus.mem_we    = bus.cpu_we;
          bus.mem_re    = bus.cpu_re;
          bus.mem_wdata = bus.cpu_wdata;
        end
        RD: begin
          bus.mem_re   = 1'b1;
          bus.mem_addr = {src_eff, index_q};
        end
        WR: begin
          bus.mem_we    = 1'b1;
          bus.mem_addr  = DEST_BASE + {8'h00, index_q};
          bus.mem_wdata = bus.mem_rdata;
        end
        default: bus.mem_addr = 16'h0000;
      endcase
    end
  end

  always_comb begin
    bus.cpu_rdata = bus.mem_rdata;
    if (bus.cpu_re && reg_hit) begin
      bus.cpu_rdata = dma_src_q;
    end else if (state_q != IDLE) begin
      bus.cpu_rdata = 8'hFF;
    end
  end

  assign bus.dma_active = (state_q != IDLE);
  assign bus.dma_src    = dma_src_q;

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// tb/tb_oam_dma_arbiter.sv - directed self-checking bench for oam_dma_arbiter
// Owns a synchronous RAM model behind mem_*; expected values are hand-computed.
module tb_oam_dma_arbiter;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  oam_dma_arbiter_if bus ();

  oam_dma_arbiter dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [7:0] mem [0:65535];

  always @(posedge clock) begin
    if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
  end

  int          active_cnt = 0;
  int          pair_err   = 0;
  int          both_err   = 0;
  logic [15:0] rd_log[$];
  logic        prev_re    = 1'b0;
  logic [15:0] prev_addr  = 16'h0000;

  // Every DMA write must copy the byte read the cycle before, at the same index.
  always @(negedge clock) begin
    if (bus.dma_active) begin
      active_cnt++;
      if (bus.mem_re && bus.mem_we) both_err++;
      if (bus.mem_re) rd_log.push_back(bus.mem_addr);
      if (bus.mem_we && !(prev_re && prev_addr[7:0] == bus.mem_addr[7:0] &&
                          bus.mem_wdata == mem[prev_addr])) pair_err++;
    end
    prev_re   = bus.dma_active && bus.mem_re;
    prev_addr = bus.mem_addr;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
    bus.cpu_we    = 1'b1;
    step();
    bus.cpu_we    = 1'b0;
  endtask

  task automatic fill(input logic [15:0] base, input int kind);
    logic [7:0] v;
    for (int i = 0; i < 160; i++) begin
      case (kind)
        0:       v = 8'h00;
        1:       v = 8'(i) ^ 8'h5A;
        2:       v = 8'(i * 7 + 3);
        default: v = 8'(i) ^ 8'hA5;
      endcase
      cpu_write(base + 16'(i), v);
    end
  endtask

  function automatic int oam_errs(input int kind);
    int e = 0;
    logic [7:0] v;
    for (int i = 0; i < 160; i++) begin
      case (kind)
        1:       v = 8'(i) ^ 8'h5A;
        2:       v = 8'(i * 7 + 3);
        default: v = 8'(i) ^ 8'hA5;
      endcase
      if (mem[16'hFE00 + 16'(i)] !== v) e++;
    end
    return e;
  endfunction

  function automatic int rd_errs(input int start, input logic [15:0] base);
    int e = 0;
    for (int i = 0; i < 160; i++)
      if (rd_log[start + i] !== base + 16'(i)) e++;
    return e;
  endfunction

  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus.dma_active && n < 1000) begin
      step();
      n++;
    end
    chk(tag, {31'd0, bus.dma_active}, 32'd0);
  endtask

  task automatic wait_for(input logic want_we, input logic [15:0] a, input string tag);
    int n = 0;
    while (!((want_we ? bus.mem_we : bus.mem_re) && bus.mem_addr == a) && n < 400) begin
      step();
      n++;
    end
    chk(tag, {31'd0, n < 400}, 32'd1);
  endtask

  int a0, r0, p0, b0;

  initial begin
    bus.cpu_addr  = 16'h0000;
    bus.cpu_we    = 1'b0;
    bus.cpu_re    = 1'b0;
    bus.cpu_wdata = 8'h00;
    bus.cpu_addr  = 16'h1234;
    bus.cpu_we    = 1'b1;
    bus.cpu_re    = 1'b1;
    #12;
    chk("rst_active", {31'd0, bus.dma_active}, 32'd0);
    chk("rst_we",     {31'd0, bus.mem_we}, 32'd0);
    chk("rst_re",     {31'd0, bus.mem_re}, 32'd0);
    chk("rst_addr",   {16'd0, bus.mem_addr}, 32'h0000);
    chk("rst_src",    {24'd0, bus.dma_src}, 32'h00);
    bus.cpu_we = 1'b0;
    bus.cpu_re = 1'b0;
    step();
    reset_n = 1'b1;
    step();

    // IDLE passthrough write and read-back
    bus.cpu_addr  = 16'hC123;
    bus.cpu_wdata = 8'h3C;
    bus.cpu_we    = 1'b1;
    #1;
    chk("pt_addr",  {16'd0, bus.mem_addr}, 32'hC123);
    chk("pt_we",    {31'd0, bus.mem_we}, 32'd1);
    chk("pt_wdata", {24'd0, bus.mem_wdata}, 32'h3C);
    step();
    bus.cpu_we = 1'b0;
    bus.cpu_re = 1'b1;
    #1;
    chk("pt_re", {31'd0, bus.mem_re}, 32'd1);
    step();
    bus.cpu_re = 1'b0;
    #1;
    chk("pt_rdata", {24'd0, bus.cpu_rdata}, 32'h3C);

    // Full transfer from C000
    fill(16'hC000, 1);
    fill(16'hFE00, 0);
    a0 = active_cnt; r0 = rd_log.size(); p0 = pair_err; b0 = both_err;
    cpu_write(16'hFF46, 8'hC0);
    wait_idle("t1_done");
    chk("t1_cycles", active_cnt - a0, 32'd321);
    chk("t1_nreads", rd_log.size() - r0, 32'd160);
    chk("t1_rdorder", rd_errs(r0, 16'hC000), 32'd0);
    chk("t1_oam", oam_errs(1), 32'd0);
    chk("t1_oam_last", {24'd0, mem[16'hFE9F]}, 32'hC5);
    chk("t1_pair", pair_err - p0, 32'd0);
    chk("t1_both", both_err - b0, 32'd0);

    // CPU access during a transfer is blocked
    fill(16'hFE00, 0);
    a0 = active_cnt; r0 = rd_log.size();
    cpu_write(16'hFF46, 8'hC0);
    repeat (20) step();
    bus.cpu_addr = 16'hC000;
    bus.cpu_re   = 1'b1;
    #1;
    chk("t2_rdata_ff", {24'd0, bus.cpu_rdata}, 32'hFF);
    chk("t2_wr_addr",  {16'd0, bus.mem_addr}, 32'hFE09);
    step();
    bus.cpu_re    = 1'b0;
    bus.cpu_addr  = 16'hC001;
    bus.cpu_wdata = 8'h11;
    bus.cpu_we    = 1'b1;
    #1;
    chk("t2_rd_addr", {16'd0, bus.mem_addr}, 32'hC00A);
    chk("t2_no_we",   {31'd0, bus.mem_we}, 32'd0);
    step();
    bus.cpu_we = 1'b0;
    wait_idle("t2_done");
    chk("t2_c001", {24'd0, mem[16'hC001]}, 32'h5B);
    chk("t2_rdorder", rd_errs(r0, 16'hC000), 32'd0);
    chk("t2_oam", oam_errs(1), 32'd0);
    chk("t2_cycles", active_cnt - a0, 32'd321);

    // Restart with a new source at index 50
    fill(16'hD000, 2);
    fill(16'hFE00, 0);
    a0 = active_cnt; r0 = rd_log.size(); p0 = pair_err;
    cpu_write(16'hFF46, 8'hC0);
    wait_for(1'b1, 16'hFE32, "t3_reach50");
    cpu_write(16'hFF46, 8'hD0);
    chk("t3_src", {24'd0, bus.dma_src}, 32'hD0);
    chk("t3_start_re", {31'd0, bus.mem_re}, 32'd0);
    step();
    chk("t3_first_rd", {16'd0, bus.mem_addr}, 32'hD000);
    wait_idle("t3_done");
    chk("t3_cycles", active_cnt - a0, 32'd424);
    chk("t3_nreads", rd_log.size() - r0, 32'd211);
    chk("t3_last_c", {16'd0, rd_log[r0 + 50]}, 32'hC032);
    chk("t3_rdorder", rd_errs(r0 + 51, 16'hD000), 32'd0);
    chk("t3_oam", oam_errs(2), 32'd0);
    chk("t3_pair", pair_err - p0, 32'd0);

    // Echo source E1 remaps to C100
    fill(16'hC100, 3);
    r0 = rd_log.size();
    cpu_write(16'hFF46, 8'hE1);
    repeat (5) step();
    bus.cpu_addr = 16'hFF46;
    bus.cpu_re   = 1'b1;
    #1;
    chk("t4_rd_ff46", {24'd0, bus.cpu_rdata}, 32'hE1);
    step();
    bus.cpu_re = 1'b0;
    wait_idle("t4_done");
    chk("t4_rdorder", rd_errs(r0, 16'hC100), 32'd0);
    chk("t4_oam", oam_errs(3), 32'd0);

    // Asynchronous reset in the middle of a transfer
    cpu_write(16'hFF46, 8'hC0);
    wait_for(1'b0, 16'hC00A, "t5_reach10");
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5_active", {31'd0, bus.dma_active}, 32'd0);
    chk("t5_we",     {31'd0, bus.mem_we}, 32'd0);
    chk("t5_re",     {31'd0, bus.mem_re}, 32'd0);
    chk("t5_src",    {24'd0, bus.dma_src}, 32'h00);
    step();
    step();
    reset_n = 1'b1;
    chk("t5_oam9",  {24'd0, mem[16'hFE09]}, 32'h53);
    chk("t5_oam10", {24'd0, mem[16'hFE0A]}, 32'hAF);
    bus.cpu_addr  = 16'hC200;
    bus.cpu_wdata = 8'h77;
    bus.cpu_we    = 1'b1;
    #1;
    chk("t5_pt_we",   {31'd0, bus.mem_we}, 32'd1);
    chk("t5_pt_addr", {16'd0, bus.mem_addr}, 32'hC200);
    step();
    bus.cpu_we = 1'b0;
    bus.cpu_re = 1'b1;
    step();
    bus.cpu_re = 1'b0;
    #1;
    chk("t5_pt_rdata", {24'd0, bus.cpu_rdata}, 32'h77);
    chk("t5_idle", {31'd0, bus.dma_active}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
